// File: rtl/linha_pkg.sv
// Shared definitions for the bottling-line master sequencer: state encoding,
// watchdog defaults and the command bundle exchanged with filler/sealer.
package linha_pkg;

    localparam int          LARGURA_TEMPO  = 26;
    localparam logic [25:0] TIMEOUT_PADRAO = 26'd50000000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ESTEIRA  = 3'd1,
        ENCHENDO = 3'd2,
        VEDANDO  = 3'd3,
        INSPECAO = 3'd4,
        LIBERA   = 3'd5,
        ERRO     = 3'd6
    } estado_t;

    // Sealer handshake: cmd_vedacao only in VEDANDO, cq_concluido only in
    // LIBERA, so the two can never be high together.
    typedef struct packed {
        logic motor_esteira;
        logic cmd_enchimento;
        logic cmd_vedacao;
        logic cq_concluido;
        logic erro_timeout;
    } saidas_t;

    function automatic saidas_t decodificar(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            ESTEIRA:  s.motor_esteira  = 1'b1;
            ENCHENDO: s.cmd_enchimento = 1'b1;
            VEDANDO:  s.cmd_vedacao    = 1'b1;
            LIBERA: begin
                s.cq_concluido  = 1'b1;
                s.motor_esteira = 1'b1;
            end
            ERRO:     s.erro_timeout   = 1'b1;
            default:  s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/temporizador_etapa.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags
// the last cycle before the limit.
module temporizador_etapa
    import linha_pkg::*;
#(
    parameter logic [25:0] LIMITE = TIMEOUT_PADRAO
) (
    input  logic clk,
    input  logic reset,
    input  logic limpar,
    input  logic habilitar,
    output logic expirou
);

    logic [LARGURA_TEMPO-1:0] tempo_q;
    logic [LARGURA_TEMPO-1:0] tempo_d;

    always_comb begin
        tempo_d = tempo_q;
        if (limpar) begin
            tempo_d = '0;
        end else if (habilitar) begin
            tempo_d = tempo_q + 26'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tempo_q <= '0;
        end else begin
            tempo_q <= tempo_d;
        end
    end

    assign expirou = (tempo_q == (LIMITE - 26'd1));

endmodule

// File: rtl/fsm_mestre_linha.sv
// Master sequencer of one bottling station: conveyor, filling, sealing
// handshake, inspection result, approved counter and watchdog error.
//
// state    | meaning
// IDLE     | line stopped, waiting for ligado and cork stock
// ESTEIRA  | conveyor running, waiting for a bottle
// ENCHENDO | filler commanded
// VEDANDO  | sealer commanded (held, watchdog frozen, during cork alarm)
// INSPECAO | waiting for the inspection verdict
// LIBERA   | sealer released, conveyor moves bottle out
// ERRO     | watchdog expired, left only by reset
module fsm_mestre_linha
    import linha_pkg::*;
#(
    parameter logic [25:0] TIMEOUT_CICLOS = TIMEOUT_PADRAO,
    parameter int          LARGURA_CONT   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ligado,
    input  logic                    sensor_garrafa,
    input  logic                    enchimento_concluido,
    input  logic                    vedacao_concluida,
    input  logic                    alarme_rolha,
    input  logic                    cq_valid,
    input  logic                    cq_aprovado,
    output logic                    motor_esteira,
    output logic                    cmd_enchimento,
    output logic                    cmd_vedacao,
    output logic                    cq_concluido,
    output logic                    descarte,
    output logic [LARGURA_CONT-1:0] cont_aprovadas,
    output logic                    erro_timeout,
    output logic [2:0]              estado
);

    localparam logic [LARGURA_CONT-1:0] UM = LARGURA_CONT'(1);

    estado_t                 estado_q, estado_d;
    saidas_t                 saidas_q, saidas_d;
    logic                    descarte_q, descarte_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic                    limpar, habilitar, expirou;

    temporizador_etapa #(
        .LIMITE (TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk       (clk),
        .reset     (reset),
        .limpar    (limpar),
        .habilitar (habilitar),
        .expirou   (expirou)
    );

    always_comb begin
        estado_d   = estado_q;
        descarte_d = 1'b0;
        cont_d     = cont_q;
        habilitar  = 1'b0;
        case (estado_q)
            IDLE: begin
                if (ligado && !alarme_rolha) estado_d = ESTEIRA;
            end
            ESTEIRA: begin
                habilitar = 1'b1;
                if (sensor_garrafa)   estado_d = ENCHENDO;
                else if (!ligado)     estado_d = IDLE;
                else if (expirou)     estado_d = ERRO;
            end
            ENCHENDO: begin
                habilitar = 1'b1;
                if (enchimento_concluido) estado_d = VEDANDO;
                else if (expirou)         estado_d = ERRO;
            end
            VEDANDO: begin
                // The sealer aborts on a cork alarm; hold here without aging.
                if (!alarme_rolha) begin
                    habilitar = 1'b1;
                    if (vedacao_concluida) estado_d = INSPECAO;
                    else if (expirou)      estado_d = ERRO;
                end
            end
            INSPECAO: begin
                habilitar = 1'b1;
                if (cq_valid) begin
                    estado_d = LIBERA;
                    if (cq_aprovado) begin
                        if (cont_q != '1) cont_d = cont_q + UM;
                    end else begin
                        descarte_d = 1'b1;
                    end
                end else if (expirou) begin
                    estado_d = ERRO;
                end
            end
            LIBERA: begin
                habilitar = 1'b1;
                if (!vedacao_concluida && !sensor_garrafa) estado_d = IDLE;
                else if (expirou)                          estado_d = ERRO;
            end
            ERRO: begin
                estado_d = ERRO;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
        limpar   = (estado_d != estado_q);
        saidas_d = decodificar(estado_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= IDLE;
            saidas_q   <= '0;
            descarte_q <= 1'b0;
            cont_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            saidas_q   <= saidas_d;
            descarte_q <= descarte_d;
            cont_q     <= cont_d;
        end
    end

    assign motor_esteira  = saidas_q.motor_esteira;
    assign cmd_enchimento = saidas_q.cmd_enchimento;
    assign cmd_vedacao    = saidas_q.cmd_vedacao;
    assign cq_concluido   = saidas_q.cq_concluido;
    assign erro_timeout   = saidas_q.erro_timeout;
    assign descarte       = descarte_q;
    assign cont_aprovadas = cont_q;
    assign estado         = estado_q;

endmodule

// File: tb/tb_fsm_mestre_linha.sv
// Bench for the bottling-line master sequencer: drives bottle flows with
// random delays and checks against a bottle-level model of the line.
module tb_fsm_mestre_linha;

    localparam int LARG = 8;
    localparam int CONT_MAX = 255;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ligado = 1'b0, sensor_garrafa = 1'b0, enchimento_concluido = 1'b0;
    logic            vedacao_concluida = 1'b0, alarme_rolha = 1'b0;
    logic            cq_valid = 1'b0, cq_aprovado = 1'b0;
    logic            motor_esteira, cmd_enchimento, cmd_vedacao, cq_concluido;
    logic            descarte, erro_timeout;
    logic [LARG-1:0] cont_aprovadas;
    logic [2:0]      estado;

    int n_testes = 0;
    int n_falhas = 0;
    int modelo_cont = 0;
    int n_desc = 0;
    int n_sobrepos = 0;

    fsm_mestre_linha #(
        .TIMEOUT_CICLOS (26'd100),
        .LARGURA_CONT   (LARG)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .ligado               (ligado),
        .sensor_garrafa       (sensor_garrafa),
        .enchimento_concluido (enchimento_concluido),
        .vedacao_concluida    (vedacao_concluida),
        .alarme_rolha         (alarme_rolha),
        .cq_valid             (cq_valid),
        .cq_aprovado          (cq_aprovado),
        .motor_esteira        (motor_esteira),
        .cmd_enchimento       (cmd_enchimento),
        .cmd_vedacao          (cmd_vedacao),
        .cq_concluido         (cq_concluido),
        .descarte             (descarte),
        .cont_aprovadas       (cont_aprovadas),
        .erro_timeout         (erro_timeout),
        .estado               (estado)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (cmd_vedacao === 1'b1 && cq_concluido === 1'b1) n_sobrepos++;
        if (descarte === 1'b1) n_desc++;
    end

    task automatic passo();
        @(negedge clk);
    endtask

    task automatic ate_esteira();
        int k;
        ligado = 1'b1;
        k = 0;
        while (estado !== 3'd1 && k < 10) begin
            passo();
            k++;
        end
        n_testes++;
        if (estado !== 3'd1 || motor_esteira !== 1'b1) begin
            n_falhas++;
            $display("FAIL esteira_entrada: estado=%0d motor=%b required estado=1 motor=1", estado, motor_esteira);
        end
    endtask

    task automatic ate_vedando(input int d_garrafa, input int d_ench, input bit mexe_ligado);
        ate_esteira();
        repeat (d_garrafa) passo();
        sensor_garrafa = 1'b1;
        passo();
        n_testes++;
        if (estado !== 3'd2 || cmd_enchimento !== 1'b1 || motor_esteira !== 1'b0) begin
            n_falhas++;
            $display("FAIL enchendo: estado=%0d ench=%b motor=%b required 2/1/0", estado, cmd_enchimento, motor_esteira);
        end
        if (mexe_ligado) ligado = 1'b0;
        repeat (d_ench) passo();
        enchimento_concluido = 1'b1;
        passo();
        n_testes++;
        if (estado !== 3'd3 || cmd_vedacao !== 1'b1 || cmd_enchimento !== 1'b0) begin
            n_falhas++;
            $display("FAIL vedando: estado=%0d ved=%b ench=%b required 3/1/0", estado, cmd_vedacao, cmd_enchimento);
        end
        enchimento_concluido = 1'b0;
        ligado = 1'b1;
    endtask

    task automatic de_vedando(input int d_ved, input int d_cq, input bit aprov, input int d_lib);
        int desc_ini;
        repeat (d_ved) passo();
        vedacao_concluida = 1'b1;
        passo();
        n_testes++;
        if (estado !== 3'd4 || cmd_vedacao !== 1'b0 || cq_concluido !== 1'b0) begin
            n_falhas++;
            $display("FAIL inspecao: estado=%0d ved=%b cq=%b required 4/0/0", estado, cmd_vedacao, cq_concluido);
        end
        repeat (d_cq) passo();
        desc_ini = n_desc;
        cq_valid = 1'b1;
        cq_aprovado = aprov;
        passo();
        cq_valid = 1'b0;
        cq_aprovado = 1'($urandom_range(0, 1));
        if (aprov && modelo_cont < CONT_MAX) modelo_cont++;
        n_testes++;
        if (estado !== 3'd5 || cq_concluido !== 1'b1 || motor_esteira !== 1'b1) begin
            n_falhas++;
            $display("FAIL libera: estado=%0d cq=%b motor=%b required 5/1/1", estado, cq_concluido, motor_esteira);
        end
        n_testes++;
        if (descarte !== !aprov || cont_aprovadas !== LARG'(modelo_cont)) begin
            n_falhas++;
            $display("FAIL veredito: descarte=%b cont=%0d required %b/%0d", descarte, cont_aprovadas, !aprov, modelo_cont);
        end
        repeat (d_lib) passo();
        vedacao_concluida = 1'b0;
        passo();
        n_testes++;
        if (estado !== 3'd5 || cq_concluido !== 1'b1) begin
            n_falhas++;
            $display("FAIL libera_espera_sensor: estado=%0d cq=%b required 5/1", estado, cq_concluido);
        end
        sensor_garrafa = 1'b0;
        passo();
        n_testes++;
        if (estado !== 3'd0 || cq_concluido !== 1'b0 || motor_esteira !== 1'b0) begin
            n_falhas++;
            $display("FAIL retorno_idle: estado=%0d cq=%b motor=%b required 0/0/0", estado, cq_concluido, motor_esteira);
        end
        n_testes++;
        if (n_desc - desc_ini !== (aprov ? 0 : 1)) begin
            n_falhas++;
            $display("FAIL pulsos_descarte: got %0d required %0d", n_desc - desc_ini, aprov ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) passo();
        n_testes++;
        if ({motor_esteira, cmd_enchimento, cmd_vedacao, cq_concluido, descarte, erro_timeout} !== 6'b0
            || estado !== 3'd0 || cont_aprovadas !== '0) begin
            n_falhas++;
            $display("FAIL reset_saidas: estado=%0d cont=%0d cmds=%b required all 0", estado, cont_aprovadas,
                     {motor_esteira, cmd_enchimento, cmd_vedacao, cq_concluido, descarte, erro_timeout});
        end
        reset = 1'b0;
        passo();
        n_testes++;
        if (estado !== 3'd0) begin
            n_falhas++;
            $display("FAIL reset_idle: estado=%0d required 0", estado);
        end
    endtask

    task automatic test_nominal();
        ate_vedando(10, 20, 1'b0);
        de_vedando(30, 4, 1'b1, 5);
    endtask

    task automatic test_rejeicao();
        ate_vedando(10, 20, 1'b0);
        de_vedando(30, 4, 1'b0, 5);
    endtask

    task automatic test_ligado();
        ate_esteira();
        passo();
        ligado = 1'b0;
        passo();
        n_testes++;
        if (estado !== 3'd0 || motor_esteira !== 1'b0) begin
            n_falhas++;
            $display("FAIL desliga_esteira: estado=%0d motor=%b required 0/0", estado, motor_esteira);
        end
        alarme_rolha = 1'b1;
        ligado = 1'b1;
        repeat (3) passo();
        n_testes++;
        if (estado !== 3'd0) begin
            n_falhas++;
            $display("FAIL idle_alarme: estado=%0d required 0", estado);
        end
        alarme_rolha = 1'b0;
        passo();
        n_testes++;
        if (estado !== 3'd1) begin
            n_falhas++;
            $display("FAIL idle_partida: estado=%0d required 1", estado);
        end
    endtask

    task automatic test_aleatorio();
        for (int i = 0; i < 15; i++) begin
            ate_vedando($urandom_range(0, 20), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
            de_vedando($urandom_range(0, 20), $urandom_range(0, 20), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 10));
        end
    endtask

    task automatic test_alarme_rolha();
        int ruins;
        ate_vedando(5, 5, 1'b0);
        alarme_rolha = 1'b1;
        ruins = 0;
        repeat (200) begin
            passo();
            if (estado !== 3'd3 || cmd_vedacao !== 1'b1) ruins++;
        end
        n_testes++;
        if (ruins != 0) begin
            n_falhas++;
            $display("FAIL alarme_rolha_espera: %0d bad cycles required 0 (estado=%0d)", ruins, estado);
        end
        alarme_rolha = 1'b0;
        de_vedando(10, 3, 1'b1, 2);
    endtask

    task automatic test_mesmo_ciclo();
        ate_esteira();
        repeat (3) passo();
        sensor_garrafa = 1'b1;
        passo();
        repeat (99) passo();
        n_testes++;
        if (estado !== 3'd2) begin
            n_falhas++;
            $display("FAIL limite_antes: estado=%0d required 2", estado);
        end
        enchimento_concluido = 1'b1;
        passo();
        n_testes++;
        if (estado !== 3'd3) begin
            n_falhas++;
            $display("FAIL saida_vence_timeout: estado=%0d required 3", estado);
        end
        enchimento_concluido = 1'b0;
        de_vedando(2, 2, 1'b1, 1);
    endtask

    task automatic test_watchdog();
        int k;
        int ruins;
        ate_esteira();
        repeat (2) passo();
        sensor_garrafa = 1'b1;
        passo();
        k = 0;
        while (estado !== 3'd6 && k < 150) begin
            passo();
            k++;
        end
        n_testes++;
        if (k != 100) begin
            n_falhas++;
            $display("FAIL watchdog_ciclos: reached ERRO after %0d cycles required 100", k);
        end
        n_testes++;
        if (erro_timeout !== 1'b1 || {motor_esteira, cmd_enchimento, cmd_vedacao, cq_concluido} !== 4'b0) begin
            n_falhas++;
            $display("FAIL erro_saidas: erro=%b cmds=%b required 1/0000", erro_timeout,
                     {motor_esteira, cmd_enchimento, cmd_vedacao, cq_concluido});
        end
        ruins = 0;
        repeat (40) begin
            ligado = 1'($urandom_range(0, 1));
            enchimento_concluido = 1'($urandom_range(0, 1));
            vedacao_concluida = 1'($urandom_range(0, 1));
            sensor_garrafa = 1'($urandom_range(0, 1));
            passo();
            if (estado !== 3'd6 || erro_timeout !== 1'b1) ruins++;
        end
        n_testes++;
        if (ruins != 0) begin
            n_falhas++;
            $display("FAIL erro_persistente: %0d bad cycles required 0", ruins);
        end
        {ligado, enchimento_concluido, vedacao_concluida, sensor_garrafa} = 4'b0;
        reset = 1'b1;
        #1;
        modelo_cont = 0;
        n_testes++;
        if (estado !== 3'd0 || erro_timeout !== 1'b0 || cont_aprovadas !== '0) begin
            n_falhas++;
            $display("FAIL erro_reset: estado=%0d erro=%b cont=%0d required 0/0/0", estado, erro_timeout, cont_aprovadas);
        end
        passo();
        reset = 1'b0;
    endtask

    task automatic test_saturacao();
        for (int i = 0; i < CONT_MAX + 1; i++) begin
            ate_vedando($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            de_vedando($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, $urandom_range(0, 2));
        end
        n_testes++;
        if (cont_aprovadas !== 8'd255) begin
            n_falhas++;
            $display("FAIL saturacao: cont=%0d required 255", cont_aprovadas);
        end
    endtask

    task automatic test_reset_async();
        ate_vedando(2, 2, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        modelo_cont = 0;
        n_testes++;
        if ({motor_esteira, cmd_enchimento, cmd_vedacao, cq_concluido, descarte, erro_timeout} !== 6'b0) begin
            n_falhas++;
            $display("FAIL reset_async_cmds: cmds=%b required 000000",
                     {motor_esteira, cmd_enchimento, cmd_vedacao, cq_concluido, descarte, erro_timeout});
        end
        n_testes++;
        if (estado !== 3'd0 || cont_aprovadas !== '0) begin
            n_falhas++;
            $display("FAIL reset_async_estado: estado=%0d cont=%0d required 0/0", estado, cont_aprovadas);
        end
        {ligado, sensor_garrafa} = 2'b0;
        passo();
        reset = 1'b0;
        passo();
        ate_vedando(3, 3, 1'b0);
        de_vedando(3, 3, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rejeicao();
        test_ligado();
        test_aleatorio();
        test_alarme_rolha();
        test_mesmo_ciclo();
        test_watchdog();
        test_saturacao();
        test_reset_async();
        passo();
        n_testes++;
        if (n_sobrepos != 0) begin
            n_falhas++;
            $display("FAIL handshake_sobreposto: %0d cycles with cmd_vedacao and cq_concluido required 0", n_sobrepos);
        end
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule

// File: doc/fsm_mestre_linha.md
# fsm_mestre_linha

Master sequencer for one bottling station: it moves the conveyor, runs filling, and initiates the sealing handshake with the sealing actuator FSM. It then collects the quality-check result and releases the sealer by asserting `cq_concluido`. It sits above the sealer, filler and inspection sensor, and drives the approved-bottle counter, discard pulse and timeout alarm shown on the board.

## Interface
Parameters:
- `TIMEOUT_CICLOS`, 26'd50000000: per-stage watchdog limit, 1 s at 50 MHz.
- `LARGURA_CONT`, 8: width of the approved-bottle counter.

Ports:
- `clk` in 1: 50 MHz clock.
- `reset` in 1: reset, asynchronous, active-high.
- `ligado` in 1: line enable switch (level).
- `sensor_garrafa` in 1: bottle present at station.
- `enchimento_concluido` in 1: filler done (level).
- `vedacao_concluida` in 1: sealer reports task done (level, held until released).
- `alarme_rolha` in 1: cork stock empty.
- `cq_valid` in 1: inspection result valid (1-cycle pulse).
- `cq_aprovado` in 1: inspection verdict, sampled with `cq_valid`.
- `motor_esteira` out 1: conveyor motor.
- `cmd_enchimento` out 1: filler command.
- `cmd_vedacao` out 1: sealer start command.
- `cq_concluido` out 1: release to sealer.
- `descarte` out 1: one-cycle reject pulse.
- `cont_aprovadas` out LARGURA_CONT: approved bottles, saturating.
- `erro_timeout` out 1: sticky watchdog error.
- `estado` out 3: current state, for debug and LEDs.

## Operation
Moore FSM. All outputs except `descarte` and `cont_aprovadas` decode from the state only.

- IDLE (0): all commands are 0.
  - Goes to ESTEIRA when `ligado && !alarme_rolha`.
- ESTEIRA (1): `motor_esteira` = 1.
  - Goes to ENCHENDO when `sensor_garrafa` = 1.
  - Goes to IDLE when `ligado` = 0. `ligado` is ignored in every other state; a bottle in process always completes.
- ENCHENDO (2): `cmd_enchimento` = 1.
  - Goes to VEDANDO when `enchimento_concluido` = 1.
- VEDANDO (3): `cmd_vedacao` = 1.
  - Goes to INSPECAO when `vedacao_concluida` = 1.
  - While `alarme_rolha` = 1, it stays in VEDANDO with the command held, and the watchdog is frozen. The sealer aborts to its idle state and restarts by itself once the alarm clears.
- INSPECAO (4): `cmd_vedacao` = 0; the sealer keeps `vedacao_concluida` high.
  - On `cq_valid`: if `cq_aprovado` = 1, `cont_aprovadas` += 1, saturating at all-ones. Otherwise `descarte` pulses for 1 cycle.
  - Then goes to LIBERA.
- LIBERA (5): `cq_concluido` = 1, `motor_esteira` = 1.
  - Goes to IDLE when `vedacao_concluida` = 0 and `sensor_garrafa` = 0.
- ERRO (6): all commands are 0 and `erro_timeout` = 1.
  - Exits only by `reset`.
- Encoding 7 is illegal and goes to IDLE next cycle.

Watchdog:
- A 26-bit timer clears on every state change.
- It increments in ESTEIRA, ENCHENDO, VEDANDO (unless `alarme_rolha`), INSPECAO and LIBERA.
- When the timer reaches `TIMEOUT_CICLOS-1` and the exit condition is false, the FSM goes to ERRO on the next edge.
- If the exit condition and the timeout occur in the same cycle, the normal exit wins.

## Timing
- Reset values: state IDLE, timer 0, all outputs 0, `cont_aprovadas` 0.
- Inputs are sampled on the rising edge. The state and the decoded outputs change 1 cycle after the qualifying input.
- Handshake order with the sealer:
  1. `cmd_vedacao` goes 1.
  2. The sealer raises `vedacao_concluida`.
  3. `cmd_vedacao` goes 0 the next cycle.
  4. After inspection, `cq_concluido` goes 1.
  5. The sealer drops `vedacao_concluida`.
  6. `cq_concluido` goes 0 no earlier than the cycle after the drop is sampled.
- `cmd_vedacao` and `cq_concluido` are never 1 in the same cycle.
- `descarte` and the counter update are registered and occur in the cycle the FSM enters LIBERA.
- `reset` mid-operation drops every command asynchronously.

## Structure
- Shared package `linha_pkg`: 3-bit state localparams, `TIMEOUT_CICLOS` default, and the sealer handshake signal conventions.
- One sub-module: `temporizador_etapa`, the watchdog.
  - Inputs: `clk`, `reset`, `limpar`, `habilitar`.
  - Output: `expirou`.
- Counter and FSM stay in the top module.

## Test plan
- Nominal, approved: `ligado`=1, bottle at cycle 10, filler done after 20 cycles, sealer done after 30, `cq_valid`/`cq_aprovado`=1.
  - `cont_aprovadas` reaches 1.
  - `cq_concluido` holds until `vedacao_concluida` falls, then the FSM returns to IDLE.
- Reject: same flow with `cq_aprovado`=0.
  - Exactly one `descarte` pulse; counter unchanged.
- Cork alarm in VEDANDO: raise `alarme_rolha` for 200 cycles with `TIMEOUT_CICLOS`=100.
  - No ERRO; `cmd_vedacao` stays 1.
  - Completion after the alarm clears proceeds normally.
- Watchdog: hold `enchimento_concluido`=0 with `TIMEOUT_CICLOS`=100.
  - ERRO is reached exactly 100 cycles after entering ENCHENDO, with all commands 0 and `erro_timeout` sticky until reset.
- Saturation and boundaries:
  - Preload 255 approvals; the 256th keeps the counter at 255.
  - Exit and timeout in the same cycle gives the normal exit.
  - `ligado`=0 in ESTEIRA gives IDLE.
- Async reset asserted mid-VEDANDO: all outputs 0 immediately, state IDLE, counter 0.
